// File: rtl/pipe_ctrl_defs.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_defs (package)
//  Description : Shared encodings for the pipeline controller: FSM states,
//                PC-select values, register index and stall counter widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_defs;

    // Width of a register-file index (x0..x31)
    localparam int REG_IDX_W   = 5;

    // Width of the saturating stall-cycle counter
    localparam int STALL_CNT_W = 16;

    // PC source selection
    localparam logic PC_SEL_PLUS4 = 1'b0;
    localparam logic PC_SEL_NEWPC = 1'b1;

    // Controller states: normal flow, branch in Execute, branch in Writeback
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        BR_E = 2'd1,
        BR_W = 2'd2
    } state_t;

endpackage : pipe_ctrl_defs
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Read-after-write hazard comparator. Flags a hazard when a
//                valid Decode instruction reads a non-zero register that a
//                valid Execute or Writeback instruction is about to write.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipe_ctrl_defs::*;
(
    input  logic                 i_vd,
    input  logic                 i_ve,
    input  logic                 i_vw,
    input  logic [REG_IDX_W-1:0] i_rs1,
    input  logic [REG_IDX_W-1:0] i_rs2,
    input  logic                 i_use_rs1,
    input  logic                 i_use_rs2,
    input  logic                 i_e_we,
    input  logic [REG_IDX_W-1:0] i_e_rd,
    input  logic                 i_w_we,
    input  logic [REG_IDX_W-1:0] i_w_rd,
    output logic                 o_hazard
);

    logic w_e_writes;
    logic w_w_writes;
    logic w_hz_rs1;
    logic w_hz_rs2;

    // A downstream stage only matters if it holds a real instruction that writes
    assign w_e_writes = i_ve & i_e_we;
    assign w_w_writes = i_vw & i_w_we;

    // x0 is hard-wired zero, so reads of it never depend on older writes
    assign w_hz_rs1 = i_vd & i_use_rs1 & (i_rs1 != '0) &
                      ((w_e_writes & (i_e_rd == i_rs1)) |
                       (w_w_writes & (i_w_rd == i_rs1)));

    assign w_hz_rs2 = i_vd & i_use_rs2 & (i_rs2 != '0) &
                      ((w_e_writes & (i_e_rd == i_rs2)) |
                       (w_w_writes & (i_w_rd == i_rs2)));

    assign o_hazard = w_hz_rs1 | w_hz_rs2;

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Control unit for a 3-stage (Decode/Execute/Writeback)
//                pipeline: stalls on RAW hazards, sequences a 3-cycle branch
//                resolution through Writeback, gates register-file writes and
//                counts stalled cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_defs::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REG_IDX_W-1:0]   d_rs1_i,
    input  logic [REG_IDX_W-1:0]   d_rs2_i,
    input  logic                   d_useRs1_i,
    input  logic                   d_useRs2_i,
    input  logic                   d_branch_i,
    input  logic                   e_regWrite_i,
    input  logic [REG_IDX_W-1:0]   e_rd_i,
    input  logic                   w_regWrite_i,
    input  logic [REG_IDX_W-1:0]   w_rd_i,
    output logic                   pc_en_o,
    output logic                   pc_sel_o,
    output logic                   fd_en_o,
    output logic                   d_valid_o,
    output logic                   e_valid_o,
    output logic                   w_valid_o,
    output logic                   rf_we_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_vd;
    logic                   r_ve;
    logic                   r_vw;
    logic                   w_vd_nxt;
    logic                   w_ve_nxt;
    logic                   w_vw_nxt;
    logic                   w_pc_en;
    logic                   w_pc_sel;
    logic                   w_fd_en;
    logic                   w_hazard;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    hazard_detect u_hazard_detect (
        .i_vd      (r_vd),
        .i_ve      (r_ve),
        .i_vw      (r_vw),
        .i_rs1     (d_rs1_i),
        .i_rs2     (d_rs2_i),
        .i_use_rs1 (d_useRs1_i),
        .i_use_rs2 (d_useRs2_i),
        .i_e_we    (e_regWrite_i),
        .i_e_rd    (e_rd_i),
        .i_w_we    (w_regWrite_i),
        .i_w_rd    (w_rd_i),
        .o_hazard  (w_hazard)
    );

    // State and stage-valid registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_vd    <= 1'b0;
            r_ve    <= 1'b0;
            r_vw    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vd    <= w_vd_nxt;
            r_ve    <= w_ve_nxt;
            r_vw    <= w_vw_nxt;
        end
    end

    // Next state, next valid bits and PC/fetch controls
    always_comb begin
        w_state_nxt = r_state;
        w_pc_en     = 1'b1;
        w_pc_sel    = PC_SEL_PLUS4;
        w_fd_en     = 1'b1;
        w_vd_nxt    = r_vd;
        w_ve_nxt    = r_ve;
        w_vw_nxt    = r_vw;
        case (r_state)
            RUN: begin
                if (w_hazard) begin
                    // Hold Decode, inject a bubble into Execute
                    w_pc_en  = 1'b0;
                    w_fd_en  = 1'b0;
                    w_ve_nxt = 1'b0;
                    w_vw_nxt = r_ve;
                end else if (r_vd && d_branch_i) begin
                    // Branch advances alone; the wrong-path fetch is dropped
                    w_pc_en     = 1'b0;
                    w_fd_en     = 1'b0;
                    w_vd_nxt    = 1'b0;
                    w_ve_nxt    = 1'b1;
                    w_vw_nxt    = r_ve;
                    w_state_nxt = BR_E;
                end else begin
                    w_vd_nxt = 1'b1;
                    w_ve_nxt = r_vd;
                    w_vw_nxt = r_ve;
                end
            end
            BR_E: begin
                w_pc_en     = 1'b0;
                w_fd_en     = 1'b0;
                w_vd_nxt    = 1'b0;
                w_ve_nxt    = 1'b0;
                w_vw_nxt    = 1'b1;
                w_state_nxt = BR_W;
            end
            BR_W: begin
                // Branch target is resolved in Writeback; redirect the PC
                w_pc_sel    = PC_SEL_NEWPC;
                w_fd_en     = 1'b0;
                w_vd_nxt    = 1'b0;
                w_ve_nxt    = 1'b0;
                w_vw_nxt    = 1'b0;
                w_state_nxt = RUN;
            end
            default: begin
                w_vd_nxt    = 1'b0;
                w_ve_nxt    = 1'b0;
                w_vw_nxt    = 1'b0;
                w_state_nxt = RUN;
            end
        endcase
    end

    // Saturating count of cycles in which the PC is not advanced
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (!w_pc_en && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign pc_en_o     = w_pc_en;
    assign pc_sel_o    = w_pc_sel;
    assign fd_en_o     = w_fd_en;
    assign d_valid_o   = r_vd;
    assign e_valid_o   = r_ve;
    assign w_valid_o   = r_vw;
    assign rf_we_o     = r_vw & w_regWrite_i;
    assign stall_cnt_o = r_stall_cnt;

endmodule : pipe_ctrl
`default_nettype wire
